// File: rtl/calc_op_sequencer.sv
// Key-event front end for the 5-bit calculator: sequences A/op/B/equals, drives the add/sub
// stage and registers its result. Optional overflow flag built only when CALC_SEQ_OVF_EN is defined.
module calc_op_sequencer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [1:0]       key_type,
  input  logic [WIDTH-1:0] key_data,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic             add_mux_select,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] result,
  output logic             result_carry,
  output logic             result_ovf,
  output logic             result_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    StIdle,
    StHaveA,
    StHaveOp,
    StHaveB,
    StExec,
    StDone
  } state_e;

  localparam logic [1:0] KeyOperand  = 2'b00;
  localparam logic [1:0] KeyOperator = 2'b01;
  localparam logic [1:0] KeyEquals   = 2'b10;
  localparam logic [1:0] KeyClear    = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (key_valid && key_type == KeyClear) begin
      // Clear wins even over the EXEC capture, so no result escapes.
      state_d  = StIdle;
      a_d      = '0;
      b_d      = '0;
      op_d     = 1'b0;
      result_d = '0;
      carry_d  = 1'b0;
    end else if (state_q == StExec) begin
      result_d = add_sum;
      carry_d  = add_cout;
      valid_d  = 1'b1;
      state_d  = StDone;
      err_d    = key_valid;
    end else if (key_valid) begin
      unique case (state_q)
        StIdle: begin
          if (key_type == KeyOperand) begin
            a_d     = key_data;
            state_d = StHaveA;
          end else begin
            err_d = 1'b1;
          end
        end
        StHaveA: begin
          if (key_type == KeyOperand) begin
            a_d = key_data;
          end else if (key_type == KeyOperator) begin
            op_d    = key_data[0];
            state_d = StHaveOp;
          end else begin
            err_d = 1'b1;
          end
        end
        StHaveOp: begin
          if (key_type == KeyOperand) begin
            b_d     = key_data;
            state_d = StHaveB;
          end else begin
            err_d = 1'b1;
          end
        end
        StHaveB: begin
          if (key_type == KeyOperand) begin
            b_d = key_data;
          end else if (key_type == KeyEquals) begin
            state_d = StExec;
          end else begin
            err_d = 1'b1;
          end
        end
        StDone: begin
          if (key_type == KeyOperator) begin
            a_d     = result_q;
            op_d    = key_data[0];
            state_d = StHaveOp;
          end else if (key_type == KeyOperand) begin
            a_d     = key_data;
            state_d = StHaveA;
          end else begin
            state_d = StExec;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

`ifdef CALC_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_calc;

  // Sub overflows when operand signs differ; add when they match. Either way the sum sign flips.
  always_comb begin
    ovf_calc = (op_q ? (a_q[WIDTH-1] != b_q[WIDTH-1]) : (a_q[WIDTH-1] == b_q[WIDTH-1]))
               && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
    ovf_d = ovf_q;
    if (key_valid && key_type == KeyClear) begin
      ovf_d = 1'b0;
    end else if (state_q == StExec) begin
      ovf_d = ovf_calc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign result_ovf = ovf_q;
`else
  assign result_ovf = 1'b0;
`endif

  assign add_a          = a_q;
  assign add_b          = b_q;
  assign add_cin        = op_q;
  assign add_mux_select = op_q;
  assign result         = result_q;
  assign result_carry   = carry_q;
  assign result_valid   = valid_q;
  assign busy           = (state_q == StExec);
  assign err            = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a behavioural 5-bit add/sub stage.
module tb_calc_op_sequencer;

  localparam int unsigned WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic             key_valid;
  logic [1:0]       key_type;
  logic [WIDTH-1:0] key_data;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic             add_mux_select;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] result;
  logic             result_carry;
  logic             result_ovf;
  logic             result_valid;
  logic             busy;
  logic             err;

  int n_cmp;
  int n_bad;

  calc_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_valid      (key_valid),
    .key_type       (key_type),
    .key_data       (key_data),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_cin        (add_cin),
    .add_mux_select (add_mux_select),
    .add_sum        (add_sum),
    .add_cout       (add_cout),
    .result         (result),
    .result_carry   (result_carry),
    .result_ovf     (result_ovf),
    .result_valid   (result_valid),
    .busy           (busy),
    .err            (err)
  );

  // Ripple add/sub stage stand-in.
  logic [WIDTH:0] full_sum;
  assign full_sum = {1'b0, add_a} + {1'b0, (add_mux_select ? ~add_b : add_b)} + {{WIDTH{1'b0}}, add_cin};
  assign add_sum  = full_sum[WIDTH-1:0];
  assign add_cout = full_sum[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CALC_SEQ_OVF_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one key for the following rising edge.
  task automatic press(input logic [1:0] t, input logic [WIDTH-1:0] d);
    key_valid = 1'b1;
    key_type  = t;
    key_data  = d;
    @(negedge clk);
    key_valid = 1'b0;
    key_type  = 2'b00;
    key_data  = '0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_type  = 2'b00;
    key_data  = '0;
    repeat (2) @(negedge clk);

    chk("rst_add_a", 8'(add_a), 8'h00);
    chk("rst_add_b", 8'(add_b), 8'h00);
    chk("rst_cin", 8'(add_cin), 8'h00);
    chk("rst_mux", 8'(add_mux_select), 8'h00);
    chk("rst_result", 8'(result), 8'h00);
    chk("rst_carry", 8'(result_carry), 8'h00);
    chk("rst_ovf", 8'(result_ovf), 8'h00);
    chk("rst_valid", 8'(result_valid), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_err", 8'(err), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // 7 + 3
    press(2'b00, 5'd7);
    press(2'b01, 5'd0);
    press(2'b00, 5'd3);
    press(2'b10, 5'd0);
    chk("add_busy", 8'(busy), 8'h01);
    chk("add_a_exec", 8'(add_a), 8'h07);
    chk("add_b_exec", 8'(add_b), 8'h03);
    chk("add_cin_exec", 8'(add_cin), 8'h00);
    chk("add_mux_exec", 8'(add_mux_select), 8'h00);
    chk("add_valid_early", 8'(result_valid), 8'h00);
    @(negedge clk);
    chk("add_valid", 8'(result_valid), 8'h01);
    chk("add_result", 8'(result), 8'h0A);
    chk("add_carry", 8'(result_carry), 8'h00);
    chk("add_ovf", 8'(result_ovf), 8'h00);
    chk("add_busy_done", 8'(busy), 8'h00);
    @(negedge clk);
    chk("add_valid_pulse", 8'(result_valid), 8'h00);

    // 3 - 5 from DONE with a fresh operand
    press(2'b00, 5'd3);
    press(2'b01, 5'd1);
    press(2'b00, 5'd5);
    press(2'b10, 5'd0);
    chk("sub_cin_exec", 8'(add_cin), 8'h01);
    chk("sub_mux_exec", 8'(add_mux_select), 8'h01);
    @(negedge clk);
    chk("sub_valid", 8'(result_valid), 8'h01);
    chk("sub_result", 8'(result), 8'h1E);
    chk("sub_carry", 8'(result_carry), 8'h00);
    chk("sub_ovf", 8'(result_ovf), 8'h00);

    // 15 + 1 signed overflow
    press(2'b00, 5'd15);
    press(2'b01, 5'd0);
    press(2'b00, 5'd1);
    press(2'b10, 5'd0);
    @(negedge clk);
    chk("ovf_result", 8'(result), 8'h10);
    chk("ovf_flag", 8'(result_ovf), 8'(OvfExp));
    chk("ovf_carry", 8'(result_carry), 8'h00);

    // Chaining: 7 + 3 = 10, then - 4
    press(2'b00, 5'd7);
    press(2'b01, 5'd0);
    press(2'b00, 5'd3);
    press(2'b10, 5'd0);
    @(negedge clk);
    chk("chain_first", 8'(result), 8'h0A);
    press(2'b01, 5'd1);
    press(2'b00, 5'd4);
    press(2'b10, 5'd0);
    chk("chain_a_exec", 8'(add_a), 8'h0A);
    chk("chain_b_exec", 8'(add_b), 8'h04);
    @(negedge clk);
    chk("chain_valid", 8'(result_valid), 8'h01);
    chk("chain_result", 8'(result), 8'h06);
    chk("chain_carry", 8'(result_carry), 8'h01);

    // Repeated equals re-executes 10 - 4
    press(2'b10, 5'd0);
    chk("reeq_busy", 8'(busy), 8'h01);
    chk("reeq_a", 8'(add_a), 8'h0A);
    @(negedge clk);
    chk("reeq_valid", 8'(result_valid), 8'h01);
    chk("reeq_result", 8'(result), 8'h06);

    // Out-of-order keys
    press(2'b11, 5'd0);
    chk("clr_result", 8'(result), 8'h00);
    chk("clr_carry", 8'(result_carry), 8'h00);
    chk("clr_err", 8'(err), 8'h00);
    press(2'b10, 5'd0);
    chk("err_eq_idle", 8'(err), 8'h01);
    chk("err_eq_idle_busy", 8'(busy), 8'h00);
    press(2'b00, 5'd9);
    chk("err_pulse_end", 8'(err), 8'h00);
    chk("err_a", 8'(add_a), 8'h09);
    press(2'b01, 5'd0);
    press(2'b01, 5'd1);
    chk("err_op_haveop", 8'(err), 8'h01);
    chk("err_op_kept", 8'(add_cin), 8'h00);
    press(2'b00, 5'd2);
    chk("err_no_valid", 8'(result_valid), 8'h00);
    press(2'b10, 5'd0);
    @(negedge clk);
    chk("err_then_result", 8'(result), 8'h0B);
    chk("err_then_valid", 8'(result_valid), 8'h01);

    // Clear while in EXEC
    press(2'b00, 5'd2);
    press(2'b01, 5'd0);
    press(2'b00, 5'd2);
    press(2'b10, 5'd0);
    chk("clrx_busy", 8'(busy), 8'h01);
    press(2'b11, 5'd0);
    chk("clrx_valid", 8'(result_valid), 8'h00);
    chk("clrx_result", 8'(result), 8'h00);
    chk("clrx_busy_after", 8'(busy), 8'h00);
    chk("clrx_err", 8'(err), 8'h00);
    chk("clrx_a", 8'(add_a), 8'h00);
    press(2'b00, 5'd1);
    press(2'b01, 5'd0);
    press(2'b00, 5'd1);
    press(2'b10, 5'd0);
    @(negedge clk);
    chk("fresh_valid", 8'(result_valid), 8'h01);
    chk("fresh_result", 8'(result), 8'h02);

    // Reset during EXEC drops the pending result
    press(2'b00, 5'd5);
    press(2'b01, 5'd0);
    press(2'b00, 5'd5);
    press(2'b10, 5'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 8'(busy), 8'h00);
    chk("midrst_result", 8'(result), 8'h00);
    chk("midrst_a", 8'(add_a), 8'h00);
    @(negedge clk);
    chk("midrst_valid", 8'(result_valid), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
